booth_pp_accumulator: RTL and testbench

- Sequential consumer of radix-8 Booth partial products, one term per cycle, from the booth_encoder stage.
- Each term is a signed partial product equal to digit*multiplicand, with digit in -4..+4, and carries its term index.
- Term i is shifted left by 3*i and summed. After NUM_TERMS terms the block presents the unsigned product on a valid/ready result port.
- Sits between booth_encoder and the multiplier result register in the Multiplier path.

---
 rtl/booth_pp_accumulator.sv | 125 ++++++++++++
 tb/tb_booth_pp_accumulator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - sequential accumulator of radix-8 Booth partial products
//
// Consumes one signed partial product (digit * multiplicand, digit in -4..+4)
// per accepted cycle. Term i is weighted by 8**i. After NUM_TERMS terms the
// unsigned product is presented on a valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pp_data    signed two's-complement partial product
//   pp_first   marks term 0 of a product (qualified by pp_valid)
//   pp_valid   term valid
//   pp_ready   block can accept a term
//   res_data   product
//   res_valid  product valid
//   res_ready  downstream accepts the product
//   term_idx   index of the next expected term
//   sync_err   sticky flag: pp_first seen mid-product; cleared only by reset
module booth_pp_accumulator #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_TERMS  = (DATA_WIDTH + 3) / 3,
  parameter int PP_WIDTH   = DATA_WIDTH + 3,
  parameter int RES_WIDTH  = 2 * DATA_WIDTH,
  parameter int TIDX_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PP_WIDTH-1:0]  pp_data,
  input  logic                 pp_first,
  input  logic                 pp_valid,
  output logic                 pp_ready,
  output logic [RES_WIDTH-1:0] res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TIDX_W-1:0]    term_idx,
  output logic                 sync_err
);

  localparam int ACC_W = PP_WIDTH + 3 * (NUM_TERMS - 1) + 1;
  localparam int SH_W  = $clog2(3 * NUM_TERMS + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic                    accept;
  logic                    restart;
  logic [TIDX_W-1:0]       eff_idx;
  logic                    last_term;
  logic [SH_W-1:0]         sh_amt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pp_ext;
  logic signed [ACC_W-1:0] sum_next;

  assign accept = pp_valid && pp_ready;

  // A term flagged first, or arriving when no product is in progress, starts
  // a fresh product: the old partial sum is dropped rather than added to.
  assign restart   = pp_first || (term_idx == '0);
  assign eff_idx   = restart ? '0 : term_idx;
  assign last_term = (eff_idx == TIDX_W'(NUM_TERMS - 1));
  assign sh_amt    = SH_W'(3 * eff_idx);

  assign pp_ext   = {{(ACC_W - PP_WIDTH){pp_data[PP_WIDTH-1]}}, pp_data};
  assign sum_next = (restart ? '0 : acc) + (pp_ext <<< sh_amt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && last_term) state_next = DONE;
      DONE:    if (res_ready)           state_next = ACCUM;
      default:                          state_next = ACCUM;
    endcase
  end

  // Output logic: the result is valid exactly while waiting in DONE, so an
  // asynchronous reset drops res_valid immediately.
  always_comb begin
    pp_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      ACCUM:   pp_ready  = 1'b1;
      DONE:    res_valid = 1'b1;
      default: pp_ready  = 1'b0;
    endcase
  end

  // Datapath: accumulator, term counter, result register, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      term_idx <= '0;
      res_data <= '0;
      sync_err <= 1'b0;
    end else if (accept) begin
      acc <= sum_next;
      if (pp_first && (term_idx != '0)) begin
        sync_err <= 1'b1;
      end
      if (last_term) begin
        // Valid Booth streams of unsigned operands sum to a non-negative
        // value below 2**RES_WIDTH, so truncation is exact.
        res_data <= sum_next[RES_WIDTH-1:0];
        term_idx <= '0;
      end else begin
        term_idx <= eff_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb/tb_booth_pp_accumulator.sv - self-checking bench for booth_pp_accumulator
module tb_booth_pp_accumulator;

  localparam int DW  = 6;
  localparam int NT  = 3;
  localparam int PPW = 9;
  localparam int RW  = 12;
  localparam int TW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PPW-1:0] pp_data = '0;
  logic           pp_first = 1'b0;
  logic           pp_valid = 1'b0;
  logic           pp_ready;
  logic [RW-1:0]  res_data;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [TW-1:0]  term_idx;
  logic           sync_err;

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed as "terms collected so far" and the
  // integer value they represent.
  bit            m_valid = 0;
  int            m_cnt   = 0;
  longint        m_sum   = 0;
  logic [RW-1:0] m_res   = '0;
  bit            m_err   = 0;
  int            m_acc_cnt = 0;
  int            exp_q[$];

  // 0: res_ready low, 1: high, 2: random each cycle
  int rr_mode = 1;

  booth_pp_accumulator #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp_data   (pp_data),
    .pp_first  (pp_first),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .term_idx  (term_idx),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_cnt   = 0;
    m_sum   = 0;
    m_res   = '0;
    m_err   = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin : mdl
    longint term;
    int     e;
    if (!rst_n) begin
      model_reset();
    end else if (m_valid) begin
      if (res_ready) m_valid = 0;
    end else if (pp_valid) begin
      term = longint'($signed(pp_data));
      m_acc_cnt++;
      if (pp_first || m_cnt == 0) begin
        if (pp_first && m_cnt != 0) m_err = 1;
        m_sum = term;
        m_cnt = 1;
      end else begin
        m_sum = m_sum + term * (longint'(1) << (3 * m_cnt));
        m_cnt++;
      end
      if (m_cnt == NT) begin
        m_res   = m_sum[RW-1:0];
        m_valid = 1;
        m_cnt   = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("model_sum_vs_axb", 64'(m_sum), 64'(e));
        end
      end
    end
  end

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    check("pp_ready",  64'(pp_ready),  64'(!m_valid));
    check("res_valid", 64'(res_valid), 64'(m_valid));
    check("res_data",  64'(res_data),  64'(m_res));
    check("term_idx",  64'(term_idx),  64'(m_cnt));
    check("sync_err",  64'(sync_err),  64'(m_err));
  end

  always @(negedge clk) begin
    #1;
    res_ready = (rr_mode == 2) ? 1'($urandom) : (rr_mode == 1);
  end

  task automatic drive_term(input logic [PPW-1:0] d, input logic f);
    int n;
    int start;
    n = 0;
    @(negedge clk);
    pp_valid = 1'b1;
    pp_data  = d;
    pp_first = f;
    start    = m_acc_cnt;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_acc_cnt == start && n < 60);
    if (m_acc_cnt == start) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: waited %0d cycles, limit 60", n);
    end
  endtask

  task automatic run_stream(input logic [PPW-1:0] t0, input logic [PPW-1:0] t1,
                            input logic [PPW-1:0] t2, input logic f0,
                            input logic [RW-1:0] exp, input string nm);
    exp_q.push_back(int'(exp));
    drive_term(t0, f0);
    drive_term(t1, 1'b0);
    drive_term(t2, 1'b0);
    @(negedge clk);
    pp_valid = 1'b0;
    pp_first = 1'b0;
    check({nm, "_latency_valid"}, 64'(res_valid), 64'(1));
    check({nm, "_data"}, 64'(res_data), 64'(exp));
    @(negedge clk);
    check({nm, "_one_cycle"}, 64'(res_valid), 64'(0));
  endtask

  initial begin : main
    int a;
    int b;
    int d;
    logic [PPW-1:0] ppv;

    rr_mode = 1;
    repeat (2) @(negedge clk);
    check("rst_pp_ready",  64'(pp_ready),  64'(1));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data",  64'(res_data),  64'(0));
    check("rst_term_idx",  64'(term_idx),  64'(0));
    check("rst_sync_err",  64'(sync_err),  64'(0));
    rst_n = 1'b1;

    run_stream(9'd159, 9'd159, 9'd0, 1'b1, 12'h597, "p53x27");
    check("p53x27_sync_err", 64'(sync_err), 64'(0));
    run_stream(9'h1CB, 9'd53, 9'd0, 1'b1, 12'h173, "p53x7");
    run_stream(9'h1C1, 9'd0, 9'd63, 1'b1, 12'hF81, "p63x63");

    // Backpressure: result held, pp_valid held high must not be taken.
    rr_mode = 0;
    exp_q.push_back(32'h597);
    drive_term(9'd159, 1'b1);
    drive_term(9'd159, 1'b0);
    drive_term(9'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pp_valid = 1'b1;
      pp_data  = 9'd21;
      pp_first = 1'b0;
      check("bp_valid",    64'(res_valid), 64'(1));
      check("bp_data",     64'(res_data),  64'(12'h597));
      check("bp_pp_ready", 64'(pp_ready),  64'(0));
    end
    exp_q.push_back(32'h173);
    rr_mode  = 1;
    pp_data  = 9'h1CB;
    pp_first = 1'b1;
    @(negedge clk);
    check("bp_release_pp_ready", 64'(pp_ready),  64'(1));
    check("bp_release_valid",    64'(res_valid), 64'(0));
    check("bp_release_idx",      64'(term_idx),  64'(0));
    @(posedge clk);
    #1;
    check("bp_first_taken_idx", 64'(term_idx), 64'(1));
    drive_term(9'd53, 1'b0);
    drive_term(9'd0, 1'b0);
    @(negedge clk);
    pp_valid = 1'b0;
    pp_first = 1'b0;
    check("bp_next_data", 64'(res_data), 64'(12'h173));
    @(negedge clk);

    // Resync: pp_first in the middle of a product restarts it.
    exp_q.push_back(32'h597);
    drive_term(9'd159, 1'b1);
    drive_term(9'd159, 1'b0);
    drive_term(9'd159, 1'b1);
    drive_term(9'd159, 1'b0);
    drive_term(9'd0, 1'b0);
    @(negedge clk);
    pp_valid = 1'b0;
    pp_first = 1'b0;
    check("resync_data",     64'(res_data), 64'(12'h597));
    check("resync_sync_err", 64'(sync_err), 64'(1));
    run_stream(9'h1C1, 9'd0, 9'd63, 1'b1, 12'hF81, "after_resync");
    check("sync_err_sticky", 64'(sync_err), 64'(1));

    // Reset mid-product.
    drive_term(9'd159, 1'b1);
    drive_term(9'd159, 1'b0);
    @(negedge clk);
    pp_valid = 1'b0;
    check("mid_idx", 64'(term_idx), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pp_ready",  64'(pp_ready),  64'(1));
    check("arst_res_valid", 64'(res_valid), 64'(0));
    check("arst_res_data",  64'(res_data),  64'(0));
    check("arst_term_idx",  64'(term_idx),  64'(0));
    check("arst_sync_err",  64'(sync_err),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(9'd159, 9'd159, 9'd0, 1'b0, 12'h597, "post_rst");

    // Randomized products with idle gaps and random res_ready.
    rr_mode = 2;
    for (int p = 0; p < 150; p++) begin
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 63));
      exp_q.push_back(a * b);
      for (int i = 0; i < NT; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          pp_valid = 1'b0;
          pp_data  = PPW'($urandom);
          pp_first = 1'($urandom);
        end
        d = -4 * ((b >> (3 * i + 2)) & 1) + 2 * ((b >> (3 * i + 1)) & 1)
            + ((b >> (3 * i)) & 1) + ((i == 0) ? 0 : ((b >> (3 * i - 1)) & 1));
        ppv = PPW'(d * a);
        drive_term(ppv, (i == 0) ? 1'($urandom) : 1'b0);
      end
    end
    @(negedge clk);
    pp_valid = 1'b0;
    rr_mode  = 1;
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("final_sync_err", 64'(sync_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
